bitserial_mac_pe: RTL
=====================

Name: bitserial_mac_pe

Overview:
- Parametrised, multi-lane, bit-serial multiply-accumulate processing element; successor to the single-bit AND/XNOR multiplier cell.
- Processes one input bit-plane across all lanes per cycle. Runtime precision 1..WBITS.
- Modes: unsigned/signed (per-operand sign flags) and binary XNOR (+1/-1).
- Sits between the activation/weight fetch buffers and the output collector; valid/ready on both sides.

Parameters:
- LANES, 4, number of parallel I×W lanes.
- WBITS, 8, maximum operand precision in bits.
- ACC_W, 24, accumulator/result width, two's complement.
- PW, $clog2(WBITS+1), width of the prec port.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  PE can accept an operand set.
- i_vec  in  LANES*WBITS  input operands; lane l at [l*WBITS +: WBITS].
- w_vec  in  LANES*WBITS  weight operands, same packing as i_vec.
- SignI  in  1  treat I as two's complement.
- SignW  in  1  treat W as two's complement.
- bin  in  1  binary XNOR mode.
- prec  in  PW  operand precision; 0 or >WBITS is clamped to WBITS.
- clear_acc  in  1  zero the accumulator before this operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_acc  out  ACC_W  accumulated result.

Behaviour:
- Reset (async, any state): state=IDLE, accumulator=0, bit counter=0, out_valid=0, out_acc=0, in_ready=1.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register i_vec, w_vec, SignI, SignW, bin and the clamped prec (P); counter k=0.
  - If clear_acc, accumulator=0 at the same edge; otherwise it keeps its value.
  - Go to RUN.
- Operand rule: only the low P bits of each lane field are used. Upper bits are ignored. Bit P-1 is the sign bit when the matching Sign flag is 1.
- RUN, normal mode (bin=0), one cycle per k = 0..P-1:
  - Wext_l = W_l sign-extended (SignW) or zero-extended from P bits.
  - ps = sum over lanes of (I_l[k] ? Wext_l : 0).
  - If SignI and k==P-1: acc -= ps<<k; else acc += ps<<k.
  - Leave RUN after k==P-1.
- RUN, binary mode (bin=1): exactly one cycle.
  - Each lane contributes +1 if I_l[0]==W_l[0], else -1.
  - acc += sum of lane contributions. P is ignored.
- Timing: in_ready=0 in RUN and DONE. Inputs are ignored outside the accepting edge.
- Latency: the edge after the last RUN cycle enters DONE. out_acc=acc and out_valid=1 there.
  - Normal mode: out_valid high P+1 cycles after the accepting edge.
  - Binary mode: 2 cycles after the accepting edge.
- DONE:
  - out_valid and out_acc are held stable until out_ready.
  - On out_valid&out_ready: out_valid=0 next edge, go to IDLE.
  - A new operand is never accepted in the same cycle as result handshake.
- out_acc keeps its last value after the handshake until the next DONE.
- Arithmetic: internal sums are at least ACC_W+1 bits. Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- Accumulation across operations: with clear_acc=0, the result adds to the previous result. Mixed bin/normal operations sum into the same accumulator.
- Reset in RUN or DONE: immediate return to the reset values; any partial result is discarded.

Optional Feature:
- Macro: BITSERIAL_MAC_SAT_EN.
- Defined: each accumulator update saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once saturated, the value is clamped at the bound and later updates start from the clamped value.
- Undefined: two's-complement wrap, no saturation logic synthesised.

Test Plan:
- Unsigned, P=8, all lanes I=3, W=5, clear_acc=1 -> out_valid 9 cycles after accept, out_acc=60.
- SignI=SignW=1, P=4: lane0 I=4'hD (-3), W=4'h7; other lanes 0; clear -> out_acc=-21 (24'hFFFFEB).
- bin=1: I bits {1,0,1,1}, W bits {1,0,1,1}, clear -> out_acc=4 two cycles after accept; then W={1,1,1,0}, no clear -> out_acc=4.
- Accumulate: repeat the first case with clear_acc=0 -> out_acc=120. Then prec=0 is clamped to 8 and gives the same 9-cycle latency.
- Backpressure and reset:
  - out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready=0, out_acc unchanged; accept completes on the out_ready pulse.
  - rst asserted mid-RUN -> same cycle out_valid=0, in_ready=1, accumulator=0.
- Overflow with ACC_W=16, unsigned, P=8, all lanes 255×255, clear:
  - Without BITSERIAL_MAC_SAT_EN -> out_acc=16'hF804.
  - With it -> 16'h7FFF.

Source files
------------

// File: rtl/bitserial_mac_pe.sv
// bitserial_mac_pe
//   Multi-lane bit-serial multiply-accumulate processing element. One bit-plane
//   of the input operands is processed across all lanes per RUN cycle, at a
//   runtime precision of 1..WBITS bits. Supports unsigned/signed operands
//   (separate sign flags for I and W) and a binary XNOR (+1/-1) mode.
//
//   Optional feature macro: BITSERIAL_MAC_SAT_EN
//     defined   -> every accumulator update saturates to the ACC_W signed range
//     undefined -> accumulator wraps modulo 2^ACC_W
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand-set handshake
//   i_vec, w_vec        lane l operand at [l*WBITS +: WBITS]
//   SignI, SignW        treat I / W as two's complement
//   bin                 binary XNOR mode
//   prec                operand precision (0 or >WBITS clamps to WBITS)
//   clear_acc           zero the accumulator at the accepting edge
//   out_valid/out_ready result handshake
//   out_acc             accumulated result (two's complement)
module bitserial_mac_pe #(
  parameter int LANES = 4,
  parameter int WBITS = 8,
  parameter int ACC_W = 24,
  parameter int PW    = $clog2(WBITS+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WBITS-1:0]   i_vec,
  input  logic [LANES*WBITS-1:0]   w_vec,
  input  logic                     SignI,
  input  logic                     SignW,
  input  logic                     bin,
  input  logic [PW-1:0]            prec,
  input  logic                     clear_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_acc
);

  // Internal width covers a full shifted partial sum on top of the
  // accumulator, so saturation can detect any single-step overflow.
  localparam int SW = ACC_W + 2*WBITS + $clog2(LANES) + 2;
  localparam logic signed [SW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LANES*WBITS-1:0]  i_q, w_q;
  logic                    signi_q, signw_q, bin_q;
  logic [PW-1:0]           p_q, k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;

  logic                    accept, run_last, run_upd;
  logic [PW-1:0]           prec_cl;
  logic [WBITS-1:0]        mask, msb, kbit;
  logic signed [SW-1:0]    ps, bs, delta, sum;
  logic signed [ACC_W-1:0] acc_next;

`ifdef BITSERIAL_MAC_SAT_EN
  function automatic logic signed [ACC_W-1:0] acc_fit(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi, lo;
    hi = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      acc_fit = hi[ACC_W-1:0];
    else if (v < lo) acc_fit = lo[ACC_W-1:0];
    else             acc_fit = v[ACC_W-1:0];
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] acc_fit(input logic signed [SW-1:0] v);
    acc_fit = v[ACC_W-1:0];
  endfunction
`endif

  assign prec_cl = ((prec == '0) || (int'(prec) > WBITS)) ? PW'(WBITS) : prec;
  assign accept  = (state_q == IDLE) && in_valid;

  // A normal operation spends P update cycles plus one settle cycle in RUN;
  // binary mode spends one update cycle plus the settle cycle.
  assign run_last = bin_q ? (k_q == PW'(1)) : (k_q == p_q);
  assign run_upd  = (state_q == RUN) && (bin_q ? (k_q == '0) : (k_q < p_q));

  // Bit-plane datapath
  always_comb begin
    logic [WBITS-1:0]     wf, ifl;
    logic signed [SW-1:0] wext;
    mask = ({{(WBITS-1){1'b0}}, 1'b1} << p_q) - 1'b1;
    msb  = mask ^ (mask >> 1);
    kbit = {{(WBITS-1){1'b0}}, 1'b1} << k_q;
    ps   = '0;
    bs   = '0;
    for (int l = 0; l < LANES; l++) begin
      wf   = w_q[l*WBITS +: WBITS];
      ifl  = i_q[l*WBITS +: WBITS];
      wext = $signed({{(SW-WBITS){1'b0}}, wf & mask});
      if (signw_q && |(wf & msb))
        wext = wext | ~$signed({{(SW-WBITS){1'b0}}, mask});
      if (|(ifl & kbit))
        ps = ps + wext;
      if (ifl[0] == wf[0]) bs = bs + ONE;
      else                 bs = bs - ONE;
    end
    if (bin_q)
      delta = bs;
    else if (signi_q && (k_q == p_q - 1'b1))
      delta = -(ps <<< k_q);
    else
      delta = ps <<< k_q;
    sum      = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q} + delta;
    acc_next = acc_fit(sum);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (run_last)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end
  assign out_acc = out_acc_q;

  // Accumulator, bit counter and result register next state
  always_comb begin
    acc_d     = acc_q;
    k_d       = k_q;
    out_acc_d = out_acc_q;
    if (accept) begin
      k_d = '0;
      if (clear_acc) acc_d = '0;
    end
    if (run_upd) acc_d = acc_next;
    if (state_q == RUN) begin
      if (run_last) out_acc_d = acc_q;
      else          k_d = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      k_q       <= '0;
      out_acc_q <= '0;
    end else begin
      acc_q     <= acc_d;
      k_q       <= k_d;
      out_acc_q <= out_acc_d;
    end
  end

  // Operand capture; data only, loaded at the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      i_q     <= i_vec;
      w_q     <= w_vec;
      signi_q <= SignI;
      signw_q <= SignW;
      bin_q   <= bin;
      p_q     <= prec_cl;
    end
  end

endmodule
